// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: RV32I load/store funct3 codes,
// responder FSM states and the funct3 legality check.
package data_mem_responder_pkg;

  localparam logic [2:0] MEM_FN_B  = 3'b000;
  localparam logic [2:0] MEM_FN_H  = 3'b001;
  localparam logic [2:0] MEM_FN_W  = 3'b010;
  localparam logic [2:0] MEM_FN_BU = 3'b100;
  localparam logic [2:0] MEM_FN_HU = 3'b101;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'b00,
    RSP_WAIT = 2'b01,
    RSP_RESP = 2'b10
  } rsp_state_e;

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic fn_illegal(input logic we, input logic [2:0] fn);
    if (we) return fn[2] || (fn == 3'b011);
    return (fn == 3'b011) || (fn == 3'b110) || (fn == 3'b111);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for 32-bit memory ports: load extraction with sign/zero
// extension, store lane replication with byte enables, and alignment checking.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  fn,
  input  logic [1:0]  addr,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic [31:0] wword,
  output logic [3:0]  byte_en,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rword >> {addr, 3'b000};
    rdata_ext  = '0;
    wword      = '0;
    byte_en    = '0;
    misaligned = 1'b0;
    case (fn)
      MEM_FN_B: begin
        rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
        wword     = {4{wdata[7:0]}};
        byte_en   = 4'b0001 << addr;
      end
      MEM_FN_BU: rdata_ext = {24'h0, shifted[7:0]};
      MEM_FN_H: begin
        rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
        wword      = {2{wdata[15:0]}};
        byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        misaligned = addr[0];
      end
      MEM_FN_HU: begin
        rdata_ext  = {16'h0, shifted[15:0]};
        misaligned = addr[0];
      end
      MEM_FN_W: begin
        rdata_ext  = rword;
        wword      = wdata;
        byte_en    = 4'b1111;
        misaligned = |addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory interface: one outstanding load/store,
// fixed LATENCY-cycle access delay, byte-enabled storage and error reporting.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int    DATA_LEN  = 32,
  parameter int    MEM_WORDS = 16384,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_fn,
  input  logic [31:0]         req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_err
);

  localparam int         AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  rsp_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic        we_p0;
  logic [2:0]  fn_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic        accept, enter_resp, do_write;
  logic        acc_we;
  logic [2:0]  acc_fn;
  logic [31:0] acc_addr, acc_wdata;
  logic [AW-1:0] acc_idx;
  logic        in_range, acc_err;
  logic [31:0] rword, rdata_ext, wword;
  logic [3:0]  byte_en;
  logic        misaligned;

  logic [31:0] mem [MEM_WORDS];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        req_ready = reset;
        if (req_valid && reset) begin
          if (LATENCY == 1) begin
            state_d = RSP_RESP;
          end else begin
            state_d = RSP_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      RSP_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RSP_RESP;
      end
      RSP_RESP: begin
        resp_valid = reset;
        state_d    = RSP_IDLE;
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  assign accept     = req_valid && req_ready;
  assign enter_resp = reset && (state_d == RSP_RESP) && (state_q != RSP_RESP);

  // With LATENCY==1 the access happens on the accepting edge, so use the live request.
  always_comb begin
    if (state_q == RSP_IDLE) begin
      acc_we    = req_we;
      acc_fn    = req_fn;
      acc_addr  = req_addr;
      acc_wdata = 32'(req_wdata);
    end else begin
      acc_we    = we_p0;
      acc_fn    = fn_p0;
      acc_addr  = addr_p0;
      acc_wdata = wdata_p0;
    end
  end

  assign acc_idx  = acc_addr[AW+1:2];
  assign in_range = acc_addr[31:2] < 30'(MEM_WORDS);
  assign rword    = mem[acc_idx];
  assign acc_err  = misaligned || !in_range || fn_illegal(acc_we, acc_fn);
  assign do_write = enter_resp && acc_we && !acc_err;

  mem_lane_align u_align (
    .fn        (acc_fn),
    .addr      (acc_addr[1:0]),
    .rword     (rword),
    .wdata     (acc_wdata),
    .rdata_ext (rdata_ext),
    .wword     (wword),
    .byte_en   (byte_en),
    .misaligned(misaligned)
  );

  // Control and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RSP_IDLE;
      cnt_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        resp_rdata <= (acc_err || acc_we) ? '0 : DATA_LEN'(rdata_ext);
        resp_err   <= acc_err;
      end
    end
  end

  // Request capture stage
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      fn_p0    <= req_fn;
      addr_p0  <= req_addr;
      wdata_p0 <= 32'(req_wdata);
    end
  end

  // Storage: byte-enabled write on the edge entering RESP
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[acc_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule
